// File: rtl/timer_counter_pkg.sv
// rtl/timer_counter_pkg.sv - shared register map, CTRL fields and FSM states for timer_counter
package timer_counter_pkg;

  localparam logic [31:0] TIMER_BASE = 32'h0000_7f00;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

endpackage

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped down-counter with one-shot and auto-reload interrupt modes
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  tc_state_e        state, state_n;
  logic [3:0]       ctrl;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count, count_n;
  logic             irq_pend;
  logic             pend_set, pend_clr, en_clr;
  logic             ctrl_wr, preset_wr;
  logic             reload;

  assign ctrl_wr   = we && (addr == REG_CTRL);
  assign preset_wr = we && (addr == REG_PRESET);
  assign reload    = (ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    en_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl[CTRL_EN]) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        count_n = preset;
        state_n = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl[CTRL_EN]) begin
          state_n = ST_IDLE;
        end else if (count > CNT_ONE) begin
          count_n = count - CNT_ONE;
        end else begin
          count_n  = '0;
          pend_set = 1'b1;
          state_n  = ST_INT;
        end
      end
      ST_INT: begin
        if (reload) begin
          pend_clr = 1'b1;
          state_n  = ST_LOAD;
        end else begin
          en_clr  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // A PRESET write parks the FSM in IDLE and overrides whatever it was about to do.
    if (preset_wr) begin
      state_n  = ST_IDLE;
      count_n  = count;
      pend_set = 1'b0;
      pend_clr = 1'b0;
      en_clr   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_pend <= 1'b0;
    end else begin
      count <= count_n;
      if (preset_wr) preset <= wdata[CNT_W-1:0];
      if (ctrl_wr) begin
        ctrl <= wdata[3:0];
      end else if (en_clr) begin
        ctrl[CTRL_EN] <= 1'b0;
      end
      // The FSM set takes priority over a CPU clear so an expiry is never dropped.
      if (pend_set) begin
        irq_pend <= 1'b1;
      end else if (ctrl_wr || pend_clr) begin
        irq_pend <= 1'b0;
      end
    end
  end

  assign irq = irq_pend & ctrl[CTRL_IM];

  always_comb begin
    rdata = '0;
    case (addr)
      REG_CTRL:   rdata = {28'd0, ctrl};
      REG_PRESET: rdata = 32'(preset);
      REG_COUNT:  rdata = 32'(count);
      default:    rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - randomized self-checking bench for timer_counter
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_counter #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  // Expected values j edges after the enabling CTRL write, derived from the timing rules:
  // COUNT is loaded two edges after enable, expiry happens M=max(N,1) edges later,
  // and auto-reload repeats with period M+2.
  function automatic logic [31:0] exp_count(int j, int n, bit rl);
    int m, k;
    m = (n < 1) ? 1 : n;
    if (j < 2) return 0;
    k = j - 2;
    if (rl) k = k % (m + 2);
    return (k < m) ? 32'(n - k) : 32'd0;
  endfunction

  function automatic bit exp_pend(int j, int n, bit rl);
    int m, k;
    m = (n < 1) ? 1 : n;
    if (j < 2) return 1'b0;
    k = j - 2;
    if (rl) return (k % (m + 2)) == m;
    return k >= m;
  endfunction

  function automatic bit exp_en(int j, int n, bit rl);
    int m;
    m = (n < 1) ? 1 : n;
    if (rl) return 1'b1;
    return j < m + 3;
  endfunction

  initial begin
    logic [31:0] d;
    int n, len;
    logic [1:0] mode;
    bit im, rl;

    reset = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    #12;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      check($sformatf("reset_held_rd%0d", a), d, 0);
    end
    check("reset_held_irq", {31'd0, irq}, 0);
    reset = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      check($sformatf("after_reset_rd%0d", a), d, 0);
    end

    wr(2'd0, 32'hffff_fff0);
    rd(2'd0, d);
    check("ctrl_upper_bits", d, 0);

    for (int t = 0; t < 12; t++) begin
      case (t)
        0: begin n = 5; mode = 2'b00; im = 1; end
        1: begin n = 3; mode = 2'b01; im = 1; end
        2: begin n = 0; mode = 2'b00; im = 1; end
        3: begin n = 1; mode = 2'b00; im = 1; end
        4: begin n = 0; mode = 2'b01; im = 1; end
        default: begin
          n    = $urandom_range(0, 9);
          mode = 2'($urandom_range(0, 3));
          im   = 1'($urandom_range(0, 1));
        end
      endcase
      rl = (mode == 2'b01);
      do_reset();
      wr(2'd1, 32'(n));
      wr(2'd0, {28'd0, im, mode, 1'b1});
      len = rl ? 2 + 4 * (((n < 1) ? 1 : n) + 2) : ((n < 1) ? 1 : n) + 6;
      for (int j = 0; j <= len; j++) begin
        rd(2'd2, d);
        check($sformatf("t%0d_n%0d_m%0d_j%0d_count", t, n, mode, j), d, exp_count(j, n, rl));
        rd(2'd0, d);
        check($sformatf("t%0d_j%0d_ctrl", t, j), d,
              {28'd0, im, mode, exp_en(j, n, rl)});
        check($sformatf("t%0d_n%0d_m%0d_im%0d_j%0d_irq", t, n, mode, im, j),
              {31'd0, irq}, {31'd0, exp_pend(j, n, rl) & im});
        tick();
      end
      if (!rl) begin
        wr(2'd0, {28'd0, 1'b1, 3'b000});
        check($sformatf("t%0d_ack_irq", t), {31'd0, irq}, 0);
      end
    end

    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(); tick();
    rd(2'd2, d);
    check("midreset_pre_count", d, 5);
    reset = 1'b0;
    #1;
    rd(2'd2, d);
    check("midreset_count", d, 0);
    check("midreset_irq", {31'd0, irq}, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rd(2'd2, d);
    check("midreset_stays_idle", d, 0);
    rd(2'd0, d);
    check("midreset_ctrl", d, 0);

    do_reset();
    wr(2'd1, 32'd8);
    wr(2'd0, 32'h1);
    for (int i = 0; i < 5; i++) tick();
    rd(2'd2, d);
    check("disable_pre_count", d, 5);
    wr(2'd0, 32'h0);
    wr(2'd2, 32'hdead_beef);
    wr(2'd3, 32'h1234_5678);
    rd(2'd3, d);
    check("addr3_reads_zero", d, 0);
    for (int i = 0; i < 8; i++) begin
      rd(2'd2, d);
      check($sformatf("disable_hold_%0d", i), d, 4);
      tick();
    end
    wr(2'd0, 32'h1);
    rd(2'd2, d);
    check("reenable_j0", d, 4);
    tick(); tick();
    rd(2'd2, d);
    check("reenable_reload", d, 8);
    tick();
    rd(2'd2, d);
    check("reenable_dec", d, 7);

    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("masked_irq_j%0d", i), {31'd0, irq}, 0);
      tick();
    end
    rd(2'd2, d);
    check("setclr_pre_count", d, 1);
    wr(2'd0, 32'h8);
    check("set_beats_clear_irq", {31'd0, irq}, 1);
    tick();
    check("set_beats_clear_hold", {31'd0, irq}, 1);
    rd(2'd0, d);
    check("set_beats_clear_ctrl", d, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
